serial_mac_sequencer: RTL and testbench

Bit-serial multiply-accumulate controller for the MAC8 datapath. It time-multiplexes one `reversible_full_adder` cell to compute `acc += A*B` with a shift-add algorithm. Operands arrive over a valid/ready handshake, and results leave on a registered output with a one-cycle valid pulse. The block is the sequencing layer between the top-level I/O wrapper and the adder cell.

---
 rtl/serial_mac_sequencer_if.sv | 25 ++
 rtl/serial_mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_serial_mac_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_mac_sequencer_if.sv
// Operand/result bundle for serial_mac_sequencer: valid/ready operand side, pulsed result side.
// The master drives operands; the slave (the sequencer) drives ready, status and results.
interface serial_mac_sequencer_if #(
    parameter int ACC_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_clr;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_clr,
        input  in_ready, acc_out, out_valid, ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_clr,
        output in_ready, acc_out, out_valid, ovf, busy
    );
endinterface

// File: rtl/serial_mac_sequencer.sv
// Bit-serial acc += A*B: one full-adder cell, 8 shift-add passes of ACC_W bit-cycles each.
// Latency 8*(ACC_W+1) edges to out_valid (MAC_SKIP_ZERO_EN: 8 + ACC_W*popcount(B)).
// Backpressure: in_ready only in IDLE; offers while busy are dropped, not queued.
module reversible_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic ctrl,
    output logic s,
    output logic cout
);
    // ctrl inverts the B leg (subtract mode); tied low it is a plain full adder.
    logic bx;
    assign bx   = b ^ ctrl;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (cin & (a ^ bx));
endmodule

module serial_mac_sequencer #(
    parameter int ACC_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_mac_sequencer_if.slave mac
);
    typedef enum logic [1:0] {IDLE, ADD, NEXT, DONE} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, a_sh, acc_out_r;
    logic [7:0]       b_sh;
    logic [2:0]       i;
    logic [4:0]       j;
    logic             carry, ovf_r, ovf_out_r;
    logic             fa_s, fa_cout;
    logic             last_bit;

    assign last_bit = (j == 5'(ACC_W - 1));

    reversible_full_adder u_fa (
        .a    (acc[0]),
        .b    (a_sh[0] & b_sh[0]),
        .cin  (carry),
        .ctrl (1'b0),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mac.in_valid) begin
`ifdef MAC_SKIP_ZERO_EN
                    state_nxt = mac.in_b[0] ? ADD : NEXT;
`else
                    state_nxt = ADD;
`endif
                end
            end
            ADD:  if (last_bit) state_nxt = NEXT;
            NEXT: begin
                if (i == 3'd7) begin
                    state_nxt = DONE;
                end else begin
`ifdef MAC_SKIP_ZERO_EN
                    // b_sh has not shifted yet, so bit 1 is the next pass's multiplier bit
                    state_nxt = b_sh[1] ? ADD : NEXT;
`else
                    state_nxt = ADD;
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            i         <= '0;
            j         <= '0;
            carry     <= 1'b0;
            ovf_r     <= 1'b0;
            acc_out_r <= '0;
            ovf_out_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mac.in_valid) begin
                        a_sh  <= {{(ACC_W-8){1'b0}}, mac.in_a};
                        b_sh  <= mac.in_b;
                        i     <= '0;
                        j     <= '0;
                        carry <= 1'b0;
                        if (mac.in_clr) begin
                            acc   <= '0;
                            ovf_r <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    // acc and a_sh rotate together; after ACC_W cycles both are realigned
                    acc  <= {fa_s, acc[ACC_W-1:1]};
                    a_sh <= {a_sh[0], a_sh[ACC_W-1:1]};
                    if (last_bit) begin
                        ovf_r <= ovf_r | fa_cout;
                        carry <= 1'b0;
                        j     <= '0;
                    end else begin
                        carry <= fa_cout;
                        j     <= j + 5'd1;
                    end
                end
                NEXT: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    i    <= i + 3'd1;
                    // publish on the edge entering DONE so results coincide with out_valid
                    if (i == 3'd7) begin
                        acc_out_r <= acc;
                        ovf_out_r <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mac.in_ready  = (state == IDLE);
    assign mac.busy      = (state != IDLE);
    assign mac.out_valid = (state == DONE);
    assign mac.acc_out   = acc_out_r;
    assign mac.ovf       = ovf_out_r;
endmodule

// File: tb/tb_serial_mac_sequencer.sv
// Scoreboard bench for serial_mac_sequencer: a driver pushes expected results at acceptance,
// a monitor pops and compares value, sticky overflow and completion cycle on every out_valid.
module tb_serial_mac_sequencer;
    localparam int     ACC_W = 20;
    localparam longint LIMIT = longint'(1) << ACC_W;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
        int               done_cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     errors = 0;
    int     checks = 0;
    int     cycle = 0;
    longint total = 0;
    exp_t   exp_q[$];

    serial_mac_sequencer_if #(.ACC_W(ACC_W)) mac_if ();

    serial_mac_sequencer #(.ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .mac (mac_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic int exp_latency(input logic [7:0] b);
`ifdef MAC_SKIP_ZERO_EN
        return 8 + ACC_W * $countones(b);
`else
        return 8 * (ACC_W + 1);
`endif
    endfunction

    // Reference: unbounded running sum since the last clear; the register holds it mod 2^ACC_W
    // and the sticky flag is set once that sum has ever reached 2^ACC_W.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic clr);
        exp_t e;
        if (clr) total = 0;
        total      = total + longint'(a) * longint'(b);
        e.acc      = ACC_W'(total % LIMIT);
        e.ovf      = (total >= LIMIT);
        e.done_cyc = cycle + 1 + exp_latency(b);
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!mac_if.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!mac_if.in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic clr);
        @(negedge clk);
        wait_ready();
        mac_if.in_valid = 1'b1;
        mac_if.in_a     = a;
        mac_if.in_b     = b;
        mac_if.in_clr   = clr;
        if (mac_if.in_ready) accept(a, b, clr);
        @(negedge clk);
        mac_if.in_valid = 1'b0;
        mac_if.in_a     = 8'($urandom);
        mac_if.in_b     = 8'($urandom);
        mac_if.in_clr   = 1'($urandom);
    endtask

    // in_valid held high with fresh operands every cycle; only IDLE-cycle offers count
    task automatic hold_valid(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            mac_if.in_valid = 1'b1;
            mac_if.in_a     = 8'($urandom);
            mac_if.in_b     = 8'($urandom);
            mac_if.in_clr   = ($urandom_range(0, 3) == 0);
            if (mac_if.in_ready) accept(mac_if.in_a, mac_if.in_b, mac_if.in_clr);
        end
        @(negedge clk);
        mac_if.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mac_if.busy) check("ready_while_busy", longint'(mac_if.in_ready), 0);
            if (mac_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_out", longint'(mac_if.acc_out), longint'(e.acc));
                    check("ovf", longint'(mac_if.ovf), longint'(e.ovf));
                    check("done_cycle", longint'(cycle), longint'(e.done_cyc));
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         n;
        mac_if.in_valid = 1'b0;
        mac_if.in_a     = '0;
        mac_if.in_b     = '0;
        mac_if.in_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(mac_if.in_ready), 1);
        check("rst_busy", longint'(mac_if.busy), 0);
        check("rst_out_valid", longint'(mac_if.out_valid), 0);
        check("rst_acc_out", longint'(mac_if.acc_out), 0);
        check("rst_ovf", longint'(mac_if.ovf), 0);
        rst = 1'b0;

        offer(8'd3, 8'd5, 1'b1);
        offer(8'd255, 8'd255, 1'b1);
        offer(8'd255, 8'd255, 1'b0);
        for (int k = 0; k < 17; k++) offer(8'd255, 8'd255, (k == 0));
        offer(8'd1, 8'd1, 1'b1);

        hold_valid(600);

        for (int k = 0; k < 15; k++) begin
            case (k % 5)
                0:       b = 8'h00;
                1:       b = 8'h01;
                2:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            offer(8'($urandom), b, ($urandom_range(0, 3) == 0));
        end

        // Abort a full-length op mid-flight
        offer(8'($urandom), 8'hFF, 1'b1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        total = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", longint'(mac_if.in_ready), 1);
        check("abort_busy", longint'(mac_if.busy), 0);
        check("abort_acc_out", longint'(mac_if.acc_out), 0);
        check("abort_ovf", longint'(mac_if.ovf), 0);
        offer(8'd2, 8'd3, 1'b0);

        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", longint'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
